// File: rtl/alu_div_8.sv
// Iterative restoring unsigned divider: one quotient bit per clock, start/done handshake.
// Optional ALU_DIV_EARLY_EXIT_EN: dividend smaller than divisor finishes in one cycle like divide-by-zero.
module alu_div_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             bypass;

  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             shortcut;

  // The remainder never exceeds the divisor, so WIDTH bits of R suffice once the
  // comparison itself is done on the shifted WIDTH+1-bit trial value.
  always_comb begin
    t      = {r, q[WIDTH-1]};
    ge     = (t >= {1'b0, dvs});
    diff   = t[WIDTH-1:0] - dvs;
    r_next = ge ? diff : t[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], ge};
  end

  always_comb begin
`ifdef ALU_DIV_EARLY_EXIT_EN
    shortcut = (b == '0) || (a < b);
`else
    shortcut = (b == '0);
`endif
  end

  // Short-path operations spend one cycle in CALC so done lands one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      r        <= '0;
      q        <= '0;
      dvs      <= '0;
      cnt      <= '0;
      bypass   <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvs      <= b;
            q        <= a;
            r        <= '0;
            cnt      <= '0;
            bypass   <= shortcut;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          if (bypass) begin
            rem   <= q;
            done  <= 1'b1;
            state <= S_DONE;
            if (dvs == '0) begin
              quot     <= '1;
              div_zero <= 1'b1;
            end else begin
              quot <= '0;
            end
          end else begin
            r   <= r_next;
            q   <= q_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              quot  <= q_next;
              rem   <= r_next;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
